// File: rtl/fu_alu_pkg.sv
// Shared opcode map and helpers for the pipelined ALU function cell.
// Optional multiplier is enabled by defining FU_ALU_MUL_EN.
package fu_alu_pkg;

    localparam int CFG_W = 4;

    localparam logic [CFG_W-1:0] OP_ADD   = 4'd0;
    localparam logic [CFG_W-1:0] OP_SUB   = 4'd1;
    localparam logic [CFG_W-1:0] OP_MUL   = 4'd2;
    localparam logic [CFG_W-1:0] OP_AND   = 4'd3;
    localparam logic [CFG_W-1:0] OP_OR    = 4'd4;
    localparam logic [CFG_W-1:0] OP_XOR   = 4'd5;
    localparam logic [CFG_W-1:0] OP_SHL   = 4'd6;
    localparam logic [CFG_W-1:0] OP_SHR   = 4'd7;
    localparam logic [CFG_W-1:0] OP_PASS0 = 4'd8;
    localparam logic [CFG_W-1:0] OP_PASS1 = 4'd9;
    localparam logic [CFG_W-1:0] OP_ASHR  = 4'd10;
    localparam logic [CFG_W-1:0] OP_SLT   = 4'd11;
    localparam logic [CFG_W-1:0] OP_EQ    = 4'd12;
    localparam logic [CFG_W-1:0] OP_ACC   = 4'd13;
    localparam logic [CFG_W-1:0] OP_LOAD  = 4'd14;

    function automatic logic is_acc_op(input logic [CFG_W-1:0] op);
        return (op == OP_ACC) || (op == OP_LOAD);
    endfunction

endpackage

// File: rtl/fu_alu_delay_line.sv
// Enable-gated valid/data delay line used for pipeline stages 2..N.
// DEPTH=0 degenerates into plain wires.
module fu_alu_delay_line #(
    parameter int W     = 32,
    parameter int DEPTH = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    input  logic         in_valid,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    output logic [W-1:0] out_data
);

    generate
        if (DEPTH == 0) begin : g_pass
            assign out_valid = in_valid;
            assign out_data  = in_data;
        end else begin : g_regs
            logic [DEPTH-1:0] v;
            logic [W-1:0]     d [DEPTH];

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    v <= '0;
                    for (int i = 0; i < DEPTH; i++) begin
                        d[i] <= '0;
                    end
                end else if (en) begin
                    v[0] <= in_valid;
                    d[0] <= in_data;
                    for (int i = 1; i < DEPTH; i++) begin
                        v[i] <= v[i-1];
                        d[i] <= d[i-1];
                    end
                end
            end

            assign out_valid = v[DEPTH-1];
            assign out_data  = d[DEPTH-1];
        end
    endgenerate

endmodule

// File: rtl/fu_alu_pipe.sv
// Elastic pipelined CGRA ALU cell with per-token opcode and accumulator.
// Define FU_ALU_MUL_EN to build the stage-1 multiplier for op 2.
module fu_alu_pipe
    import fu_alu_pkg::*;
#(
    parameter int size   = 32,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [CFG_W-1:0] config_sig,
    input  logic [size-1:0]  in0,
    input  logic [size-1:0]  in1,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             acc_clr,
    output logic [size-1:0]  out0,
    output logic             out_valid,
    input  logic             out_ready
);

    localparam logic [size-1:0] SZ = size'(size);

    logic            adv;
    logic            accept;
    logic            shift_big;
    logic            s1_valid;
    logic [size-1:0] s1_data;
    logic [size-1:0] result;
    logic [size-1:0] acc;
    logic [size-1:0] acc_base;
    logic [size-1:0] acc_sum;

    // Single global advance: a stalled head freezes the whole pipe.
    assign adv      = ~out_valid | out_ready;
    assign in_ready = adv;
    assign accept   = in_valid & adv;

    // Clear in the same cycle as an accumulate makes the op see zero.
    assign acc_base  = acc_clr ? '0 : acc;
    assign acc_sum   = acc_base + in0;
    assign shift_big = (in1 >= SZ);

    always_comb begin
        result = '0;
        case (config_sig)
            OP_ADD:   result = in0 + in1;
            OP_SUB:   result = in0 - in1;
`ifdef FU_ALU_MUL_EN
            OP_MUL:   result = in0 * in1;
`endif
            OP_AND:   result = in0 & in1;
            OP_OR:    result = in0 | in1;
            OP_XOR:   result = in0 ^ in1;
            OP_SHL:   result = shift_big ? '0 : (in0 << in1);
            OP_SHR:   result = shift_big ? '0 : (in0 >> in1);
            OP_ASHR: begin
                if (shift_big) begin
                    result = {size{in0[size-1]}};
                end else begin
                    result = $unsigned($signed(in0) >>> in1);
                end
            end
            OP_PASS0: result = in0;
            OP_PASS1: result = in1;
            OP_SLT:   result = {{(size-1){1'b0}}, ($signed(in0) < $signed(in1))};
            OP_EQ:    result = {{(size-1){1'b0}}, (in0 == in1)};
            OP_ACC:   result = acc_sum;
            OP_LOAD:  result = in0;
            default:  result = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_data  <= '0;
        end else if (adv) begin
            s1_valid <= in_valid;
            s1_data  <= in_valid ? result : '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc <= '0;
        end else if (accept && is_acc_op(config_sig)) begin
            acc <= (config_sig == OP_ACC) ? acc_sum : in0;
        end else if (acc_clr) begin
            acc <= '0;
        end
    end

    fu_alu_delay_line #(
        .W     (size),
        .DEPTH (STAGES - 1)
    ) u_delay (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (adv),
        .in_valid  (s1_valid),
        .in_data   (s1_data),
        .out_valid (out_valid),
        .out_data  (out0)
    );

endmodule

// File: tb/tb_fu_alu_pipe.sv
// Randomized bench for fu_alu_pipe against a spec-level reference model.
// Builds with or without FU_ALU_MUL_EN.
module tb_fu_alu_pipe;

    localparam int W = 32;
    localparam int STAGES = 2;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [3:0]    config_sig;
    logic [W-1:0]  in0;
    logic [W-1:0]  in1;
    logic          in_valid;
    logic          in_ready;
    logic          acc_clr;
    logic [W-1:0]  out0;
    logic          out_valid;
    logic          out_ready;

    int checks = 0;
    int errors = 0;

    logic [W-1:0] got  [$];
    logic [W-1:0] mexp [$];
    logic [W-1:0] macc;

    fu_alu_pipe #(.size(W), .STAGES(STAGES)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .config_sig (config_sig),
        .in0        (in0),
        .in1        (in1),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .acc_clr    (acc_clr),
        .out0       (out0),
        .out_valid  (out_valid),
        .out_ready  (out_ready)
    );

    always #5 clk = ~clk;

    function automatic logic [W-1:0] ref_alu(input logic [3:0] op,
                                             input logic [W-1:0] a,
                                             input logic [W-1:0] b,
                                             input logic [W-1:0] base);
        longint sa;
        longint sb;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (op)
            4'd0:  return a + b;
            4'd1:  return a - b;
`ifdef FU_ALU_MUL_EN
            4'd2:  return W'(64'(a) * 64'(b));
`endif
            4'd3:  return a & b;
            4'd4:  return a | b;
            4'd5:  return a ^ b;
            4'd6:  return (b >= W) ? '0 : W'(64'(a) * (64'd1 << b));
            4'd7:  return (b >= W) ? '0 : W'(64'(a) / (64'd1 << b));
            4'd8:  return a;
            4'd9:  return b;
            4'd10: begin
                if (b >= W) return a[W-1] ? '1 : '0;
                return (a >> b) | (a[W-1] ? ~({W{1'b1}} >> b) : '0);
            end
            4'd11: return (sa < sb) ? 1 : 0;
            4'd12: return (a == b) ? 1 : 0;
            4'd13: return base + a;
            4'd14: return a;
            default: return '0;
        endcase
    endfunction

    // One clock: drive at negedge, record output/accept before the edge.
    task automatic step(input logic v, input logic [3:0] op,
                        input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic clr, input logic ordy);
        logic [W-1:0] base;
        in_valid = v; config_sig = op; in0 = a; in1 = b;
        acc_clr = clr; out_ready = ordy;
        #1;
        if (out_valid && ordy) got.push_back(out0);
        base = clr ? '0 : macc;
        if (v && in_ready) begin
            mexp.push_back(ref_alu(op, a, b, base));
            if (op == 4'd13) macc = base + a;
            else if (op == 4'd14) macc = a;
            else macc = base;
        end else begin
            macc = base;
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drain();
        int n = 0;
        while (got.size() < mexp.size() && n < 40) begin
            step(0, 0, 0, 0, 0, 1);
            n++;
        end
        repeat (3) step(0, 0, 0, 0, 0, 1);
        if (got.size() < mexp.size()) begin
            checks++; errors++;
            $display("FAIL drain_timeout: got %0d outputs, required %0d",
                     got.size(), mexp.size());
        end
    endtask

    task automatic test_reset();
        checks++;
        if (out_valid !== 1'b0) begin
            errors++; $display("FAIL reset_out_valid: got %b required 0", out_valid);
        end
        checks++;
        if (out0 !== '0) begin
            errors++; $display("FAIL reset_out0: got %h required 0", out0);
        end
        checks++;
        if (in_ready !== 1'b1) begin
            errors++; $display("FAIL reset_in_ready: got %b required 1", in_ready);
        end
    endtask

    task automatic test_latency_b2b();
        got.delete(); mexp.delete();
        step(1, 4'd0, 5, 7, 0, 1);
        checks++;
        if (out_valid !== 1'b0) begin
            errors++; $display("FAIL lat_early: out_valid %b required 0", out_valid);
        end
        step(0, 0, 0, 0, 0, 1);
        checks++;
        if (out_valid !== 1'b1 || out0 !== 32'd12) begin
            errors++;
            $display("FAIL lat_add: out_valid %b out0 %h required 1 / 0000000c",
                     out_valid, out0);
        end
        for (int i = 0; i < 8; i++) begin
            step(1, 4'($urandom_range(0, 12)), $urandom, $urandom_range(0, 40), 0, 1);
            if (i >= 1) begin
                checks++;
                if (out_valid !== 1'b1) begin
                    errors++; $display("FAIL b2b_valid[%0d]: got %b required 1", i, out_valid);
                end
            end
        end
        drain();
        checks++;
        if (got.size() !== mexp.size()) begin
            errors++; $display("FAIL b2b_count: got %0d required %0d", got.size(), mexp.size());
        end
        for (int i = 0; i < got.size() && i < mexp.size(); i++) begin
            checks++;
            if (got[i] !== mexp[i]) begin
                errors++; $display("FAIL b2b_data[%0d]: got %h required %h", i, got[i], mexp[i]);
            end
        end
    endtask

    task automatic test_directed();
        logic [W-1:0] req [3];
        req[0] = 32'hFFFF_FFFF; req[1] = 32'hFFFF_FFFF; req[2] = 32'h0;
        got.delete(); mexp.delete();
        step(1, 4'd1, 0, 1, 0, 1);
        step(1, 4'd10, 32'h8000_0000, 40, 0, 1);
        step(1, 4'd6, 32'h8000_0000, 40, 0, 1);
        drain();
        checks++;
        if (got.size() !== 3) begin
            errors++; $display("FAIL dir_count: got %0d required 3", got.size());
        end
        for (int i = 0; i < got.size() && i < 3; i++) begin
            checks++;
            if (got[i] !== req[i]) begin
                errors++; $display("FAIL dir_data[%0d]: got %h required %h", i, got[i], req[i]);
            end
        end
    endtask

    task automatic test_stall();
        logic [W-1:0] held;
        got.delete(); mexp.delete();
        step(1, 4'd8, 32'h111, 0, 0, 1);
        step(1, 4'd8, 32'h222, 0, 0, 1);
        held = out0;
        for (int i = 0; i < 5; i++) begin
            step(1, 4'd8, 32'h333, 0, 0, 0);
            checks++;
            if (out0 !== held || out_valid !== 1'b1 || in_ready !== 1'b0) begin
                errors++;
                $display("FAIL stall[%0d]: out0 %h v %b rdy %b required %h 1 0",
                         i, out0, out_valid, in_ready, held);
            end
        end
        step(1, 4'd8, 32'h333, 0, 0, 1);
        drain();
        checks++;
        if (got.size() !== 3) begin
            errors++; $display("FAIL stall_count: got %0d required 3", got.size());
        end
        for (int i = 0; i < got.size() && i < 3; i++) begin
            checks++;
            if (got[i] !== W'((i + 1) * 32'h111)) begin
                errors++;
                $display("FAIL stall_data[%0d]: got %h required %h", i, got[i], (i + 1) * 32'h111);
            end
        end
    endtask

    task automatic test_acc();
        logic [W-1:0] req [4];
        req[0] = 10; req[1] = 13; req[2] = 17; req[3] = 2;
        got.delete(); mexp.delete();
        step(1, 4'd14, 10, 0, 0, 1);
        step(1, 4'd13, 3, 0, 0, 1);
        step(1, 4'd13, 4, 0, 0, 1);
        step(1, 4'd13, 2, 0, 1, 1);
        drain();
        checks++;
        if (got.size() !== 4) begin
            errors++; $display("FAIL acc_count: got %0d required 4", got.size());
        end
        for (int i = 0; i < got.size() && i < 4; i++) begin
            checks++;
            if (got[i] !== req[i]) begin
                errors++; $display("FAIL acc_data[%0d]: got %h required %h", i, got[i], req[i]);
            end
        end
        got.delete(); mexp.delete();
        step(1, 4'd14, 50, 0, 1, 1);
        step(1, 4'd13, 1, 0, 0, 1);
        drain();
        checks++;
        if (got.size() !== 2 || got[0] !== 50 || got[1] !== 51) begin
            errors++; $display("FAIL acc_load_wins: got %p required 50,51", got);
        end
    endtask

    task automatic test_mul_reserved();
        got.delete(); mexp.delete();
        step(1, 4'd2, 32'h0001_0000, 32'h0001_0000, 0, 1);
        step(0, 0, 0, 0, 0, 1);
        checks++;
        if (out_valid !== 1'b1 || out0 !== 32'h0) begin
            errors++; $display("FAIL mul_wrap: v %b out0 %h required 1 0", out_valid, out0);
        end
        step(1, 4'd15, 32'h1234, 32'h5678, 0, 1);
        step(1, 4'd2, 3, 5, 0, 1);
        drain();
        checks++;
        if (got.size() !== 3) begin
            errors++; $display("FAIL mul_count: got %0d required 3", got.size());
        end else begin
            checks++;
            if (got[1] !== 32'h0) begin
                errors++; $display("FAIL op15: got %h required 0", got[1]);
            end
            checks++;
`ifdef FU_ALU_MUL_EN
            if (got[2] !== 32'd15) begin
                errors++; $display("FAIL mul_3x5: got %h required f", got[2]);
            end
`else
            if (got[2] !== 32'd0) begin
                errors++; $display("FAIL mul_off: got %h required 0", got[2]);
            end
`endif
        end
    endtask

    task automatic test_random();
        logic [W-1:0] b;
        got.delete(); mexp.delete();
        for (int i = 0; i < 300; i++) begin
            b = ($urandom_range(0, 2) == 0) ? W'($urandom_range(0, 40)) : W'($urandom);
            if ($urandom_range(0, 5) == 0) b = $urandom_range(0, 1) ? 32'h8000_0000 : 0;
            step($urandom_range(0, 3) != 0, 4'($urandom_range(0, 15)), $urandom, b,
                 $urandom_range(0, 9) == 0, $urandom_range(0, 3) != 0);
        end
        drain();
        checks++;
        if (got.size() !== mexp.size()) begin
            errors++; $display("FAIL rnd_count: got %0d required %0d", got.size(), mexp.size());
        end
        for (int i = 0; i < got.size() && i < mexp.size(); i++) begin
            checks++;
            if (got[i] !== mexp[i]) begin
                errors++; $display("FAIL rnd_data[%0d]: got %h required %h", i, got[i], mexp[i]);
            end
        end
    endtask

    task automatic test_reset_mid();
        step(1, 4'd14, 32'h55, 0, 0, 1);
        step(1, 4'd8, 32'hDEAD, 0, 0, 1);
        step(1, 4'd8, 32'hBEEF, 0, 0, 0);
        rst_n = 1'b0; in_valid = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || dut.acc !== '0 || out0 !== '0) begin
            errors++;
            $display("FAIL mid_reset: v %b acc %h out0 %h required 0 0 0",
                     out_valid, dut.acc, out0);
        end
        @(posedge clk); @(negedge clk);
        @(posedge clk); @(negedge clk);
        rst_n = 1'b1;
        got.delete(); mexp.delete(); macc = '0;
        step(1, 4'd9, 0, 32'hABCD, 0, 1);
        step(1, 4'd13, 7, 0, 0, 1);
        drain();
        checks++;
        if (got.size() !== 2 || got[0] !== 32'hABCD || got[1] !== 32'd7) begin
            errors++; $display("FAIL post_reset: got %p required abcd,7", got);
        end
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; config_sig = '0;
        in0 = '0; in1 = '0; acc_clr = 1'b0; out_ready = 1'b1;
        macc = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        test_reset();
        rst_n = 1'b1;
        @(posedge clk); @(negedge clk);
        test_latency_b2b();
        test_directed();
        test_stall();
        test_acc();
        test_mul_reserved();
        test_random();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
